// File: rtl/bf_pkg.sv
// Shared constants and the streamer state type for the Bellman-Ford result drain path.
// Output memory geometry is fixed here; the streamed node count is a parameter of the top.
package bf_pkg;

  localparam int          ADDR_W           = 13;
  localparam int          DATA_W           = 16;
  localparam int          SUM_W            = 29;
  localparam int          NUM_NODES_DEFAULT = 8192;
  localparam logic [15:0] DIST_INF         = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    NEG,
    DONE
  } state_e;

endpackage

// File: rtl/bf_result_streamer_if.sv
// Valid/ready stream carrying one distance word plus its node index and flags.
// The streamer drives the master side; the consumer drives out_ready.
interface bf_result_streamer_if;
  import bf_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_inf;
  logic              out_last;

  modport master (
    output out_valid, out_data, out_index, out_inf, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_index, out_inf, out_last,
    output out_ready
  );

endinterface

// File: rtl/bf_result_stats.sv
// Running statistics over accepted reachable distances: count, maximum and sum.
// Only built when BF_STATS_EN is defined.
module bf_result_stats
  import bf_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_accept,
  input  logic [DATA_W-1:0] i_data,
  output logic [ADDR_W:0]   o_reach_count,
  output logic [DATA_W-1:0] o_max_dist,
  output logic [SUM_W-1:0]  o_dist_sum
);

  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_max;
  logic [SUM_W-1:0]  r_sum;

  // 29-bit sum holds 8192 x 16'hFFFE with room to spare, so no saturation is needed.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
      r_max   <= '0;
      r_sum   <= '0;
    end else if (i_accept) begin
      r_count <= r_count + (ADDR_W+1)'(1);
      if (i_data > r_max) r_max <= i_data;
      r_sum   <= r_sum + SUM_W'(i_data);
    end
  end

  assign o_reach_count = r_count;
  assign o_max_dist    = r_max;
  assign o_dist_sum    = r_sum;

endmodule

// File: rtl/bf_result_streamer.sv
// Drains the Bellman-Ford output memory over a valid/ready stream once Finish rises,
// or reports a negative cycle instead. Optional statistics under macro BF_STATS_EN.
module bf_result_streamer
  import bf_pkg::*;
#(
  parameter int NUM_NODES = NUM_NODES_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Finish,
  input  logic              NegCycle,
  output logic [ADDR_W-1:0] OMAR,
  input  logic [DATA_W-1:0] OMDR,
  bf_result_streamer_if.master s_out,
  output logic [ADDR_W:0]   reach_count,
  output logic [DATA_W-1:0] max_dist,
  output logic [SUM_W-1:0]  dist_sum,
  output logic              neg_flag,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NODES - 1);

  state_e            r_state, w_state_next;
  logic [ADDR_W-1:0] r_rd_idx, r_index;
  logic [DATA_W-1:0] r_data;
  logic              r_valid, r_inf, r_last, r_neg, r_done;
  logic              w_hs, w_load, w_end, w_set_neg;

  assign w_hs = r_valid & s_out.out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_end        = 1'b0;
    w_set_neg    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (NegCycle)    w_state_next = NEG;
        else if (Finish) w_state_next = FETCH;
      end
      FETCH: begin
        w_load       = 1'b1;
        w_state_next = SEND;
      end
      SEND: begin
        if (w_hs) begin
          if (r_last) begin
            w_end        = 1'b1;
            w_state_next = DONE;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      NEG:     w_set_neg = 1'b1;
      DONE:    ;
      default: w_state_next = IDLE;
    endcase
  end

  // A load captures the combinational read of r_rd_idx and advances the pointer;
  // the pointer may wrap after the last word, which is never read again.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_idx <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_index  <= '0;
      r_inf    <= 1'b0;
      r_last   <= 1'b0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_load) begin
        r_data   <= OMDR;
        r_index  <= r_rd_idx;
        r_inf    <= (OMDR == DIST_INF);
        r_last   <= (r_rd_idx == LAST_IDX);
        r_rd_idx <= r_rd_idx + ADDR_W'(1);
        r_valid  <= 1'b1;
      end
      if (w_end) begin
        r_valid <= 1'b0;
        r_done  <= 1'b1;
      end
      if (w_set_neg) begin
        r_neg  <= 1'b1;
        r_done <= 1'b1;
      end
    end
  end

  assign OMAR            = r_rd_idx;
  assign s_out.out_valid = r_valid;
  assign s_out.out_data  = r_data;
  assign s_out.out_index = r_index;
  assign s_out.out_inf   = r_inf;
  assign s_out.out_last  = r_last;
  assign neg_flag        = r_neg;
  assign done            = r_done;

`ifdef BF_STATS_EN
  bf_result_stats u_stats (
    .clock         (clock),
    .reset         (reset),
    .i_accept      (w_hs & ~r_inf),
    .i_data        (r_data),
    .o_reach_count (reach_count),
    .o_max_dist    (max_dist),
    .o_dist_sum    (dist_sum)
  );
`else
  assign reach_count = '0;
  assign max_dist    = '0;
  assign dist_sum    = '0;
`endif

endmodule
